// File: rtl/fsqrt_former.sv
// Seed stage of the fp32 square root: table lookup plus linear interpolation
// giving x ~ 2^31/sqrt(om) in Q31, over a two-entry valid/ready pipeline.
module fsqrt_former #(
    parameter int ADDR_W   = 10,
    parameter int SLOPE_W  = 16,
    parameter int SLOPE_SH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_s,
    output logic [63:0] out_x
);

    localparam int MB     = ADDR_W - 1;
    localparam int D_W    = 24 - ADDR_W;
    localparam int WORD_W = 32 + SLOPE_W;
    localparam int PROD_W = SLOPE_W + D_W;
    localparam int DEPTH  = 1 << ADDR_W;

    function automatic logic [127:0] isqrt(input logic [127:0] n);
        logic [127:0] r;
        logic [127:0] b;
        logic [127:0] rem;
        r   = '0;
        rem = n;
        b   = 128'd1 << 126;
        for (int i = 0; i < 64; i++) begin
            if (rem >= r + b) begin
                rem = rem - (r + b);
                r   = (r >> 1) + b;
            end else begin
                r = r >> 1;
            end
            b = b >> 2;
        end
        return r;
    endfunction

    // 2^31/sqrt(om) at segment k, rounded; odd exponent gives om in [1,2)
    function automatic logic [31:0] seg_f(input int k, input logic odd);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] r;
        num = 128'd1 << (odd ? 64 + MB : 63 + MB);
        den = 128'(k) + (128'd1 << MB);
        r   = (isqrt(num / den) + 128'd1) >> 1;
        return r[31:0];
    endfunction

    function automatic logic [WORD_W-1:0] rom_word(input int i);
        logic [ADDR_W-1:0] idx;
        logic [31:0]       b0;
        logic [31:0]       b1;
        logic [63:0]       diff;
        logic [63:0]       sl;
        idx  = i[ADDR_W-1:0];
        b0   = seg_f(int'(idx[MB-1:0]), idx[MB]);
        b1   = seg_f(int'(idx[MB-1:0]) + 1, idx[MB]);
        diff = 64'(b0) - 64'(b1);
        sl   = ((diff << SLOPE_SH) + (64'd1 << (D_W - 1))) >> D_W;
        if (sl > (64'd1 << SLOPE_W) - 64'd1)
            sl = (64'd1 << SLOPE_W) - 64'd1;
        return {b0, sl[SLOPE_W-1:0]};
    endfunction

    logic [WORD_W-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [WORD_W-1:0] WORD = rom_word(g);
        assign rom[g] = WORD;
    end

    logic              va_q;
    logic              vb_q;
    logic [31:0]       sa_q;
    logic [D_W-1:0]    d_q;
    logic [WORD_W-1:0] rom_q;
    logic [31:0]       sb_q;
    logic [31:0]       xb_q;

    logic              adv_a;
    logic              adv_b;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       base;
    logic [PROD_W-1:0] prod;
    logic [31:0]       prod_sh;
    logic [31:0]       x_d;

    assign adv_b    = ~vb_q | out_ready;
    assign adv_a    = ~va_q | adv_b;
    assign in_ready = adv_a;

    assign addr    = in_s[23:23-MB];
    assign base    = rom_q[WORD_W-1:SLOPE_W];
    assign prod    = {{D_W{1'b0}}, rom_q[SLOPE_W-1:0]}
                   * {{SLOPE_W{1'b0}}, d_q};
    assign prod_sh = 32'(prod >> SLOPE_SH);
    assign x_d     = base - prod_sh;

    // Operand/ROM registers hold on stall; no reset needed, va_q qualifies them
    always_ff @(posedge clk) begin
        if (adv_a && in_valid) begin
            sa_q  <= in_s;
            d_q   <= in_s[D_W-1:0];
            rom_q <= rom[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q <= 1'b0;
            vb_q <= 1'b0;
            sb_q <= '0;
            xb_q <= '0;
        end else begin
            if (adv_a)
                va_q <= in_valid;
            if (adv_b) begin
                vb_q <= va_q;
                if (va_q) begin
                    assert (prod_sh <= base);
                    sb_q <= sa_q;
                    xb_q <= x_d;
                end
            end
        end
    end

    assign out_valid = vb_q;
    assign out_s     = sb_q;
    assign out_x     = {32'b0, xb_q};

endmodule
